// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus (DAC, preamp, ADC): grants one requester
// at a time, runs its framed transfer and reports completion plus captured ADC data.
module spi_bus_arbiter #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] dac_word,
  input  logic [7:0]  amp_gain,
  output logic [2:0]  done,
  output logic        busy,
  output logic [33:0] adc_data,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        dac_cs,
  output logic        spi_amp_cs,
  output logic        spi_adc_conv,
  output logic        spi_rom_cs
);

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_t;

  state_t      state;
  logic [7:0]  timer;
  logic [5:0]  bit_cnt;
  logic [30:0] tx_shift;
  logic [33:0] rx_shift;
  logic [1:0]  grant;
  logic [1:0]  last_grant;
  logic [1:0]  arb_idx;

  assign spi_rom_cs = 1'b1;

  // First requester after last_grant in wrap order 0 -> 1 -> 2 -> 0.
  always_comb begin
    arb_idx = 2'd0;
    case (last_grant)
      2'd0: begin
        if (req[1])      arb_idx = 2'd1;
        else if (req[2]) arb_idx = 2'd2;
        else             arb_idx = 2'd0;
      end
      2'd1: begin
        if (req[2])      arb_idx = 2'd2;
        else if (req[0]) arb_idx = 2'd0;
        else             arb_idx = 2'd1;
      end
      default: begin
        if (req[0])      arb_idx = 2'd0;
        else if (req[1]) arb_idx = 2'd1;
        else             arb_idx = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      grant        <= '0;
      last_grant   <= 2'd2;
      busy         <= 1'b0;
      done         <= '0;
      adc_data     <= '0;
      spi_sck      <= 1'b0;
      spi_mosi     <= 1'b0;
      dac_cs       <= 1'b1;
      spi_amp_cs   <= 1'b1;
      spi_adc_conv <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant      <= arb_idx;
            last_grant <= arb_idx;
            busy       <= 1'b1;
            timer      <= SETUP_M1;
            rx_shift   <= '0;
            state      <= SETUP;
            // The MSB goes straight to MOSI; tx_shift keeps only the bits still to send.
            case (arb_idx)
              2'd0: begin
                tx_shift <= dac_word[30:0];
                spi_mosi <= dac_word[31];
                bit_cnt  <= 6'd31;
                dac_cs   <= 1'b0;
              end
              2'd1: begin
                tx_shift   <= {amp_gain[6:0], 24'h0};
                spi_mosi   <= amp_gain[7];
                bit_cnt    <= 6'd7;
                spi_amp_cs <= 1'b0;
              end
              default: begin
                tx_shift     <= '0;
                spi_mosi     <= 1'b0;
                bit_cnt      <= 6'd33;
                spi_adc_conv <= 1'b1;
              end
            endcase
          end
        end

        SETUP: begin
          if (timer == '0) begin
            spi_adc_conv <= 1'b0;
            timer        <= DIV_M1;
            state        <= SHIFT_LO;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        SHIFT_LO: begin
          if (timer == '0) begin
            spi_sck  <= 1'b1;
            rx_shift <= {rx_shift[32:0], spi_miso};
            timer    <= DIV_M1;
            state    <= SHIFT_HI;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        SHIFT_HI: begin
          if (timer == '0) begin
            spi_sck <= 1'b0;
            if (bit_cnt == '0) begin
              timer <= HOLD_M1;
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt - 6'd1;
              spi_mosi <= tx_shift[30];
              tx_shift <= {tx_shift[29:0], 1'b0};
              timer    <= DIV_M1;
              state    <= SHIFT_LO;
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end

        HOLD: begin
          if (timer == '0) begin
            dac_cs     <= 1'b1;
            spi_amp_cs <= 1'b1;
            spi_mosi   <= 1'b0;
            done       <= 3'b001 << grant;
            if (grant == 2'd2) adc_data <= rx_shift;
            state      <= GAP;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: an abstract arbitration/timing model queues
// expected frames; a bus monitor reconstructs each frame and checks it at its done pulse.
module tb_spi_bus_arbiter;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned CS_SETUP = 1;
  localparam int unsigned CS_HOLD  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [31:0] dac_word = '0;
  logic [7:0]  amp_gain = '0;
  logic [2:0]  done;
  logic        busy;
  logic [33:0] adc_data;
  logic        spi_miso = 1'b0;
  logic        spi_mosi;
  logic        spi_sck;
  logic        dac_cs;
  logic        spi_amp_cs;
  logic        spi_adc_conv;
  logic        spi_rom_cs;

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .dac_word    (dac_word),
    .amp_gain    (amp_gain),
    .done        (done),
    .busy        (busy),
    .adc_data    (adc_data),
    .spi_miso    (spi_miso),
    .spi_mosi    (spi_mosi),
    .spi_sck     (spi_sck),
    .dac_cs      (dac_cs),
    .spi_amp_cs  (spi_amp_cs),
    .spi_adc_conv(spi_adc_conv),
    .spi_rom_cs  (spi_rom_cs)
  );

  typedef struct {
    int unsigned     dev;
    logic [31:0]     data;
    logic [33:0]     adc;
    longint unsigned grant_cyc;
    longint unsigned done_cyc;
  } frame_t;

  frame_t          exp_q[$];
  int unsigned     n_vec = 0;
  int unsigned     n_err = 0;
  int unsigned     n_done = 0;
  longint unsigned cyc = 0;
  longint unsigned next_free = 0;
  int unsigned     last_dev = 2;
  logic [33:0]     exp_adc = '0;
  logic [33:0]     adc_pat_next = 34'h2_AAAA_5555;
  logic [33:0]     miso_pat = '0;

  function automatic int unsigned frame_bits(int unsigned dev);
    return (dev == 0) ? 32 : (dev == 1) ? 8 : 34;
  endfunction

  function automatic longint unsigned frame_len(int unsigned dev);
    return longint'(CS_SETUP + 2 * CLK_DIV * frame_bits(dev) + CS_HOLD);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: bus free -> grant next requester in round-robin order; the bus
  // is then owned for setup + 2*div*N + hold cycles plus one gap, and re-arbitrates after that.
  always @(posedge clk) begin
    frame_t      f;
    int unsigned pick;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      last_dev  = 2;
      next_free = 0;
      exp_adc   = '0;
    end else if (cyc >= next_free && req != 3'b000) begin
      pick = 0;
      for (int unsigned k = 1; k <= 3; k++) begin
        if (req[(last_dev + k) % 3]) begin
          pick = (last_dev + k) % 3;
          break;
        end
      end
      f.dev  = pick;
      f.data = (pick == 0) ? dac_word : (pick == 1) ? {24'h0, amp_gain} : 32'h0;
      if (pick == 2) begin
        exp_adc      = adc_pat_next;
        miso_pat     = adc_pat_next;
        adc_pat_next = {2'($urandom_range(3)), 32'($urandom)};
      end
      f.adc       = exp_adc;
      f.grant_cyc = cyc;
      f.done_cyc  = cyc + frame_len(pick);
      next_free   = cyc + frame_len(pick) + 2;
      last_dev    = pick;
      exp_q.push_back(f);
    end
  end

  // Bus monitor, ADC MISO model and scoreboard checker.
  logic            prev_sck = 1'b0;
  logic            adc_active = 1'b0;
  int              miso_idx = 0;
  logic            in_frame = 1'b0;
  int unsigned     obs_dev = 0;
  int unsigned     rises = 0;
  int unsigned     sel_cyc = 0;
  int unsigned     conv_cyc = 0;
  logic [63:0]     mosi_bits = '0;
  longint unsigned start_cyc = 0;

  always @(negedge clk) begin
    frame_t      f;
    int unsigned nsel;
    logic        exp_busy;
    if (!rst_n) begin
      in_frame   = 1'b0;
      adc_active = 1'b0;
      prev_sck   = 1'b0;
    end else begin
      nsel     = 32'(!dac_cs) + 32'(!spi_amp_cs) + 32'(spi_adc_conv);
      exp_busy = (exp_q.size() != 0);
      check("select_overlap", 64'(nsel > 1), 64'(0));
      check("busy", 64'(busy), 64'(exp_busy));
      if (!exp_busy) check("idle_bus", 64'({spi_sck, nsel != 0}), 64'(0));

      if (!in_frame && nsel != 0) begin
        in_frame  = 1'b1;
        obs_dev   = !dac_cs ? 0 : !spi_amp_cs ? 1 : 2;
        rises     = 0;
        sel_cyc   = 0;
        conv_cyc  = 0;
        mosi_bits = '0;
        start_cyc = cyc;
      end
      if (in_frame) begin
        if (!dac_cs || !spi_amp_cs) sel_cyc++;
        if (spi_adc_conv) conv_cyc++;
        if (spi_sck && !prev_sck) begin
          rises++;
          mosi_bits = {mosi_bits[62:0], spi_mosi};
        end
      end

      if (spi_adc_conv) begin
        adc_active = 1'b1;
        miso_idx   = 33;
        spi_miso   = miso_pat[33];
      end else if (adc_active) begin
        if (!spi_sck && prev_sck && miso_idx > 0) begin
          miso_idx--;
          spi_miso = miso_pat[miso_idx];
        end
      end else begin
        spi_miso = 1'($urandom);
      end

      if (done != 3'b000) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          f = exp_q.pop_front();
          check("done_onehot", 64'(done), 64'(3'b001 << f.dev));
          check("done_cycle", 64'(cyc), 64'(f.done_cyc));
          check("frame_seen", 64'(in_frame), 64'(1));
          check("frame_dev", 64'(obs_dev), 64'(f.dev));
          check("grant_cycle", 64'(start_cyc), 64'(f.grant_cyc));
          check("sck_count", 64'(rises), 64'(frame_bits(f.dev)));
          if (f.dev == 2) begin
            check("conv_cycles", 64'(conv_cyc), 64'(CS_SETUP));
            check("adc_no_select", 64'(sel_cyc), 64'(0));
            check("adc_mosi_zero", 64'(mosi_bits[33:0]), 64'(0));
          end else begin
            check("select_cycles", 64'(sel_cyc), 64'(frame_len(f.dev)));
            check("conv_idle", 64'(conv_cyc), 64'(0));
            check("mosi_data", (f.dev == 0) ? 64'(mosi_bits[31:0]) : 64'(mosi_bits[7:0]),
                  64'(f.data));
          end
          check("adc_data", 64'(adc_data), 64'(f.adc));
          check("gap_selects", 64'({dac_cs, spi_amp_cs, spi_adc_conv, spi_rom_cs}), 64'(4'b1101));
        end
        in_frame = 1'b0;
        if (done[2]) adc_active = 1'b0;
      end
      prev_sck = spi_sck;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(int unsigned n, int unsigned bound);
    int unsigned target = n_done + n;
    int unsigned t = 0;
    while (n_done < target && t < bound) begin
      tick();
      t++;
    end
    if (n_done < target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done: got %0d done pulses, required %0d", n_done, target);
    end
  endtask

  task automatic wait_idle(int unsigned bound);
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: got %0d frames pending, required 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_sck", 64'(spi_sck), 64'(0));
    check("rst_mosi", 64'(spi_mosi), 64'(0));
    check("rst_dac_cs", 64'(dac_cs), 64'(1));
    check("rst_amp_cs", 64'(spi_amp_cs), 64'(1));
    check("rst_conv", 64'(spi_adc_conv), 64'(0));
    check("rst_rom_cs", 64'(spi_rom_cs), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int unsigned t;
    repeat (3) tick();
    check_reset_outputs();
    check("rst_adc_data", 64'(adc_data), 64'(0));
    rst_n = 1'b1;
    tick();

    // All three at once: DAC, AMP, ADC in order.
    dac_word = 32'h0030_8000;
    amp_gain = 8'h11;
    req      = 3'b111;
    wait_dones(3, 1000);
    req = 3'b000;
    wait_idle(400);

    // Single-cycle DAC request, data changed right after grant.
    req = 3'b001;
    tick();
    req      = 3'b000;
    dac_word = 32'hDEAD_BEEF;
    wait_idle(400);

    // AMP alone.
    amp_gain = 8'h11;
    req      = 3'b010;
    wait_dones(1, 400);
    req = 3'b000;
    wait_idle(400);

    // ADC alone with the fixed MISO pattern.
    adc_pat_next = 34'h2_AAAA_5555;
    req          = 3'b100;
    wait_dones(1, 400);
    req = 3'b000;
    wait_idle(400);

    // ADC and DAC held; AMP joins during a DAC frame.
    dac_word = 32'h1234_5678;
    req      = 3'b101;
    wait_dones(3, 1500);
    t = 0;
    while (!(in_frame && obs_dev == 0) && t < 600) begin
      tick();
      t++;
    end
    check("dac_frame_found", 64'(in_frame && obs_dev == 0), 64'(1));
    req = 3'b111;
    wait_dones(4, 2000);
    req = 3'b000;
    wait_idle(400);

    // Randomised request patterns and payloads.
    for (int i = 0; i < 40; i++) begin
      req      = 3'($urandom);
      dac_word = $urandom;
      amp_gain = 8'($urandom);
      repeat ($urandom_range(1, 150)) tick();
    end
    req = 3'b000;
    wait_idle(400);

    // Reset during the 10th SCK of a DAC frame.
    dac_word = 32'hA5A5_0F0F;
    req      = 3'b001;
    t = 0;
    while (!(in_frame && obs_dev == 0 && rises == 10) && t < 600) begin
      tick();
      t++;
    end
    check("tenth_sck_found", 64'(rises), 64'(10));
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_done_in_reset", 64'(done), 64'(0));
    end
    rst_n = 1'b1;
    wait_dones(1, 400);
    req = 3'b000;
    wait_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
